// File: rtl/ysyx_220066_mdu_pkg.sv
// Shared constants for the RV64M multiply/divide sequencer: funct3 codes,
// W-variant bit position, FSM state encoding and iteration-count defaults.
package ysyx_220066_mdu_pkg;

    localparam int ITER_D_DEF = 64;
    localparam int ITER_W_DEF = 32;
    localparam int W_BIT      = 3;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_220066_mdu_if.sv
// Request/response bus between the EXU and the multi-cycle M-extension unit.
interface ysyx_220066_mdu_if #(
    parameter int XLEN = 64
);
    // Both channels: a transfer happens on a rising edge where valid & ready;
    // the producer holds valid and its payload stable until that edge.
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      mdu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, mdu_op, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, mdu_op, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/ysyx_220066_mdu_step.sv
// One combinational iteration: shift-add multiply or restoring divide step
// on the {hi, lo} accumulator pair.
module ysyx_220066_mdu_step
    import ysyx_220066_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] mcand,
    output logic [XLEN-1:0] hi_nx,
    output logic [XLEN-1:0] lo_nx
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   r_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        r_sh = {hi, lo[XLEN-1]};
        ge   = r_sh >= {1'b0, mcand};
        // When ge holds the true difference is below mcand, so XLEN bits suffice.
        diff = r_sh[XLEN-1:0] - mcand;
        if (is_div) begin
            hi_nx = ge ? diff : r_sh[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], ge};
        end else begin
            hi_nx = sum[XLEN:1];
            lo_nx = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ysyx_220066_mdu_ctrl.sv
// RV64M sequencer: operand prep, iteration FSM, sign fix-up and fast paths.
// Define YSYX_220066_MDU_ZERO_SKIP_EN to short-circuit zero operands.
module ysyx_220066_mdu_ctrl
    import ysyx_220066_mdu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ITER_D = ITER_D_DEF,
    parameter int ITER_W = ITER_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    ysyx_220066_mdu_if.slave   bus,
    output mdu_state_e         dbg_state
);

    localparam int CW = $clog2(ITER_D);

    mdu_state_e      state, state_nx;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_r;
    logic            w_r, sa_r, sb_r;
    logic [XLEN-1:0] hi, lo, mcand, res_r, hi_nx, lo_nx;

    logic            w_in, is_div_in, rem_in, zext_in, s1_signed, s2_signed, sa, sb;
    logic [2:0]      f3_in;
    logic [XLEN-1:0] a_p, b_p, a_mag, b_mag, fast_raw, fast_res;
    logic            accept, div_zero, div_ovf, zero_skip, fast;

    always_comb begin
        w_in      = bus.mdu_op[W_BIT];
        f3_in     = bus.mdu_op[2:0];
        is_div_in = f3_in[2];
        rem_in    = f3_in[1];
        zext_in   = w_in & (f3_in == F3_DIVU || f3_in == F3_REMU);
        a_p       = bus.src1;
        b_p       = bus.src2;
        if (w_in) begin
            a_p = zext_in ? {32'b0, bus.src1[31:0]} : sext32(bus.src1[31:0]);
            b_p = zext_in ? {32'b0, bus.src2[31:0]} : sext32(bus.src2[31:0]);
        end
        s1_signed = (f3_in == F3_MUL) || (f3_in == F3_MULH) || (f3_in == F3_MULHSU)
                    || (f3_in == F3_DIV) || (f3_in == F3_REM);
        s2_signed = (f3_in == F3_MUL) || (f3_in == F3_MULH)
                    || (f3_in == F3_DIV) || (f3_in == F3_REM);
        sa    = s1_signed & a_p[XLEN-1];
        sb    = s2_signed & b_p[XLEN-1];
        a_mag = sa ? -a_p : a_p;
        b_mag = sb ? -b_p : b_p;

        div_zero = is_div_in & (b_p == '0);
        div_ovf  = is_div_in & (f3_in == F3_DIV || f3_in == F3_REM) & (b_p == '1)
                   & (a_p == (w_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
`ifdef YSYX_220066_MDU_ZERO_SKIP_EN
        zero_skip = is_div_in ? ((a_p == '0) && (b_p != '0)) : ((a_p == '0) || (b_p == '0));
`else
        zero_skip = 1'b0;
`endif
        fast = div_zero | div_ovf | zero_skip;

        // Zero-skip results are all zero, which is the default here.
        fast_raw = '0;
        if (div_zero)     fast_raw = rem_in ? a_p : '1;
        else if (div_ovf) fast_raw = rem_in ? '0 : a_p;
        fast_res = w_in ? sext32(fast_raw[31:0]) : fast_raw;
    end

    assign bus.in_ready  = (state == IDLE) & ~flush;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_r;
    assign dbg_state     = state;
    assign accept        = bus.in_valid & bus.in_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = fast ? DONE : CALC;
            CALC:    if (flush) state_nx = IDLE; else if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = flush ? IDLE : DONE;
            DONE:    if (flush || bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    ysyx_220066_mdu_step #(.XLEN(XLEN)) u_step (
        .is_div (f3_r[2]),
        .hi     (hi),
        .lo     (lo),
        .mcand  (mcand),
        .hi_nx  (hi_nx),
        .lo_nx  (lo_nx)
    );

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   fix_raw, fix_res;

    // A W multiply stops 32 shifts early, leaving the product 32 bits high.
    always_comb begin
        prod    = w_r ? {32'b0, hi, lo[XLEN-1:32]} : {hi, lo};
        prod_s  = (sa_r ^ sb_r) ? -prod : prod;
        case (f3_r)
            F3_MUL:                       fix_raw = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_raw = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_raw = (sa_r ^ sb_r) ? -lo : lo;
            default:                      fix_raw = sa_r ? -hi : hi;
        endcase
        fix_res = w_r ? sext32(fix_raw[31:0]) : fix_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            f3_r  <= '0;
            w_r   <= 1'b0;
            sa_r  <= 1'b0;
            sb_r  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            res_r <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    f3_r <= f3_in;
                    w_r  <= w_in;
                    sa_r <= sa;
                    sb_r <= sb;
                    cnt  <= w_in ? CW'(ITER_W - 1) : CW'(ITER_D - 1);
                    hi   <= '0;
                    if (is_div_in) begin
                        mcand <= b_mag;
                        lo    <= w_in ? {a_mag[31:0], 32'b0} : a_mag;
                    end else begin
                        mcand <= a_mag;
                        lo    <= b_mag;
                    end
                    if (fast) res_r <= fast_res;
                end
                CALC: begin
                    hi <= hi_nx;
                    lo <= lo_nx;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: if (!flush) res_r <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_mdu_ctrl.sv
// Directed bench for the M-extension sequencer: arithmetic-level reference
// model with an expected queue, per-cycle compare, plus literal vectors.
module tb_ysyx_220066_mdu_ctrl;
  import ysyx_220066_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  mdu_state_e dbg_state;

  ysyx_220066_mdu_if #(.XLEN(64)) bus ();

  ysyx_220066_mdu_ctrl #(.XLEN(64), .ITER_D(64), .ITER_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

`ifdef YSYX_220066_MDU_ZERO_SKIP_EN
  localparam int ZS_LAT = 1;
`else
  localparam int ZS_LAT = 66;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  function automatic void prep(input logic [3:0] op, input logic [63:0] s1, s2,
                               output logic [63:0] a, output logic [63:0] b);
    if (op[3] && (op[2:0] == 3'd5 || op[2:0] == 3'd7)) begin
      a = {32'b0, s1[31:0]};
      b = {32'b0, s2[31:0]};
    end else if (op[3]) begin
      a = {{32{s1[31]}}, s1[31:0]};
      b = {{32{s2[31]}}, s2[31:0]};
    end else begin
      a = s1;
      b = s2;
    end
  endfunction

  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] s1, s2);
    logic [63:0] a, b, r, minv;
    logic signed [127:0] p;
    logic [127:0] pu;
    prep(op, s1, s2, a, b);
    minv = op[3] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    r = '0;
    case (op[2:0])
      3'd0: r = a * b;
      3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[127:64]; end
      3'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = p[127:64]; end
      3'd3: begin pu = {64'b0, a} * {64'b0, b}; r = pu[127:64]; end
      3'd4, 3'd6: begin
        if (b == 64'd0) r = (op[2:0] == 3'd4) ? ONES : a;
        else if (a == minv && b == ONES) r = (op[2:0] == 3'd4) ? a : 64'd0;
        else r = (op[2:0] == 3'd4) ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
      end
      default: begin
        if (b == 64'd0) r = (op[2:0] == 3'd5) ? ONES : a;
        else r = (op[2:0] == 3'd5) ? a / b : a % b;
      end
    endcase
    if (op[3]) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Edges from accept to the first edge where the result can be taken.
  function automatic int model_lat(input logic [3:0] op, input logic [63:0] s1, s2);
    logic [63:0] a, b, minv;
    logic quick;
    prep(op, s1, s2, a, b);
    minv = op[3] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    quick = op[2] && (b == 64'd0 || (!op[0] && a == minv && b == ONES));
`ifdef YSYX_220066_MDU_ZERO_SKIP_EN
    quick = quick || (op[2] ? (a == 64'd0 && b != 64'd0) : (a == 64'd0 || b == 64'd0));
`endif
    return quick ? 1 : (op[3] ? ITER_W_DEF + 2 : ITER_D_DEF + 2);
  endfunction

  // scoreboard: per-cycle compare against the model
  initial begin : compare
    bit busy;
    int cyc;
    int lat;
    logic ev;
    busy = 1'b0;
    cyc = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        exp_q.delete();
        continue;
      end
      chk("in_ready", bus.in_ready, !busy && !flush);
      ev = busy && (cyc >= lat);
      chk("out_valid", bus.out_valid, ev);
      if (ev && exp_q.size() > 0) chk("result", bus.result, exp_q[0]);
      if (busy) begin
        if (flush) begin
          busy = 1'b0;
          void'(exp_q.pop_front());
        end else if (ev && bus.out_ready) begin
          busy = 1'b0;
          void'(exp_q.pop_front());
        end else begin
          cyc++;
        end
      end else if (bus.in_valid && !flush) begin
        busy = 1'b1;
        cyc = 1;
        lat = model_lat(bus.mdu_op, bus.src1, bus.src2);
        exp_q.push_back(model_res(bus.mdu_op, bus.src1, bus.src2));
      end
    end
  end

  // driver tasks
  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.mdu_op = 4'd0;
    bus.src1 = 64'd0;
    bus.src2 = 64'd0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [63:0] a, b);
    @(posedge clk); #2;
    bus.in_valid = 1'b1;
    bus.mdu_op = op;
    bus.src1 = a;
    bus.src2 = b;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    bus.mdu_op = 4'($urandom_range(0, 15));
    bus.src1 = {$urandom, $urandom};
    bus.src2 = {$urandom, $urandom};
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a, b,
                        input logic [63:0] exp, input int lat, input int hold);
    int c;
    logic [63:0] first;
    start_op(op, a, b);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.out_valid && c < 200);
    chk({name, "_lat"}, c, lat);
    chk(name, bus.result, exp);
    first = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_res"}, bus.result, first);
      chk({name, "_hold_hs"}, {bus.in_ready, bus.out_valid}, 2'b01);
    end
    @(posedge clk); #2 bus.out_ready = 1'b1;
    @(posedge clk); #2 bus.out_ready = 1'b0;
  endtask

  initial begin : stim
    drive_idle();
    #12;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk); #2 rst_n = 1'b1;

    run_op("mul",      4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0);
    run_op("mulhu",    4'h3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("mulh",     4'h1, ONES, ONES, 64'd0, 66, 0);
    run_op("mulhsu",   4'h2, ONES, 64'd2, ONES, 66, 0);
    run_op("div_ovf",  4'h4, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf",  4'h6, 64'h8000_0000_0000_0000, ONES, 64'd0, 1, 0);
    run_op("divu_z",   4'h5, 64'd123, 64'd0, ONES, 1, 0);
    run_op("remu_z",   4'h7, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("remw_z",   4'hE, 64'h1_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, 0);
    run_op("divw_ovf", 4'hC, 64'h1_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("remw",     4'hE, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 34, 10);
    run_op("mulw",     4'h8, 64'h1_0000_0002, 64'd3, 64'd6, 34, 0);
    run_op("div_neg",  4'h4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, 0);
    run_op("rem_neg",  4'h6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("divuw",    4'hD, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34, 0);
    run_op("divu",     4'h5, 64'd100, 64'd7, 64'd14, 66, 0);
    run_op("mul_zero", 4'h0, 64'd0, 64'd5, 64'd0, ZS_LAT, 0);
    run_op("div_zdvd", 4'h4, 64'd0, 64'd7, 64'd0, ZS_LAT, 0);

    // flush in the middle of an iteration
    start_op(4'h0, 64'd5, 64'd6);
    repeat (10) @(posedge clk);
    #2 flush = 1'b1;
    #1 chk("flush_rdy_low", bus.in_ready, 1'b0);
    @(posedge clk); #2 flush = 1'b0;
    #1 chk("flush_rdy_high", bus.in_ready, 1'b1);
    chk("flush_state", dbg_state, IDLE);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      chk("flush_no_valid", bus.out_valid, 1'b0);
    end

    // flush together with a request: nothing may be accepted
    @(posedge clk); #2;
    bus.in_valid = 1'b1;
    bus.mdu_op = 4'h0;
    bus.src1 = 64'd2;
    bus.src2 = 64'd3;
    flush = 1'b1;
    #1 chk("flush_acc_rdy", bus.in_ready, 1'b0);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_acc_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    end

    // asynchronous reset while iterating
    start_op(4'h0, 64'd9, 64'd9);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_state", dbg_state, IDLE);
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    run_op("mul_after_rst", 4'h0, 64'd2, 64'd3, 64'd6, 66, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_mdu_ctrl.md
Name: ysyx_220066_mdu_ctrl

Overview:
- Multi-cycle sequencer for the RV64M multiply/divide extension. It sits beside the single-cycle ALU in the EXU stage.
- Accepts one M-op at a time over a valid/ready handshake and iterates a radix-2 shift-add multiplier or a restoring divider. It handles sign fix-up and the RISC-V corner cases itself.
- Returns a 64-bit result over a second valid/ready handshake. A flush input kills the op in flight on a pipeline redirect.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- ITER_D, 64, iterations for double-word ops.
- ITER_W, 32, iterations for word (W-suffix) ops.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  op request
- in_ready  out  1  block can accept an op
- mdu_op  in  4  bit3 = W variant; bits[2:0] = funct3 (0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu)
- src1  in  64  rs1 operand
- src2  in  64  rs2 operand
- flush  in  1  abort the current op
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  64  final value

Behaviour:
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, counter 0.
- FSM states: IDLE, CALC, FIX, DONE.
  - in_ready = (state == IDLE) & ~flush.
  - An op is accepted on an edge where in_valid & in_ready. Operands and op are latched on that edge.
- IDLE to CALC on accept. The counter loads ITER-1, where ITER = W ? ITER_W : ITER_D.
- CALC performs one iteration per edge. When the counter reaches 0, go to FIX.
- FIX, one cycle: apply negation (sign fix-up), then W sign-extension. Go to DONE.
- DONE: out_valid = 1 and result is held stable. Return to IDLE on out_valid & out_ready. No new op is accepted in DONE.
- Latency:
  - Call the accept edge E0. out_valid is high from the cycle after edge E(ITER+1).
  - So the result is first takeable at edge ITER+2: 66 cycles for D ops, 34 for W ops.
- Operand preparation:
  - W ops take src[31:0]. divuw and remuw zero-extend; all other W ops sign-extend.
  - Signedness per operand:
    - mulh: s/s
    - mulhsu: s/u
    - mulhu: u/u
    - mul: don't care
    - div and rem: s/s
    - divu and remu: u/u
  - Magnitudes are taken before iterating.
- Multiply:
  - The unsigned product is 2*XLEN wide. It is negated in FIX when the two operand signs differ.
  - mul returns the low XLEN bits; mulh, mulhsu and mulhu return the high XLEN bits.
  - mulw returns sign-ext(low 32 bits).
- Divide:
  - Restoring division.
  - Quotient sign = s1 ^ s2. Remainder sign = dividend sign.
  - W results are sign-extended from bit 31.
- Fast path (always on): accept goes directly to DONE, with out_valid on the next cycle.
  - Divisor zero: quotient = all ones; remainder = the dividend after width preparation and sign-extension.
  - Signed overflow (most-negative / -1 for the width): quotient = the most negative value, sign-extended; remainder = 0.
- flush:
  - In CALC, FIX or DONE: go to IDLE on the next edge and drop the result; out_valid goes 0.
  - While flush is asserted, in_ready = 0, so nothing is accepted in that cycle.
  - flush has priority over out_ready.
- Asynchronous reset mid-operation: immediately returns to the reset values.
- mdu_op is a don't-care while not in IDLE.

Optional Feature:
- YSYX_220066_MDU_ZERO_SKIP_EN
- Defined:
  - Multiply with either prepared operand equal to 0 takes the fast path: result 0, next cycle.
  - Divide/rem with dividend 0 and nonzero divisor takes the fast path: quotient 0, remainder 0.
- Undefined: these cases iterate normally with full latency.
- Results are identical either way; only latency differs.

Decomposition:
- Package ysyx_220066_mdu_pkg:
  - funct3 op constants
  - W bit position
  - state encoding (IDLE, CALC, FIX, DONE)
  - ITER_D and ITER_W defaults
- One sub-module, ysyx_220066_mdu_step: combinational single iteration step.
  - Multiply: conditional add and shift of the {hi, lo} accumulator.
  - Divide: trial subtract, restore and quotient-bit shift.
  - The controller owns all registers, the counter and the FSM.

Test Plan:
- Multiply, D variants:
  - mul src1 = 7, src2 = -3 → result 0xFFFF_FFFF_FFFF_FFEB; out_valid first high 66 cycles after accept.
  - mulhu 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE.
  - mulh -1 × -1 → 0.
- Signed overflow:
  - div 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000.
  - rem of the same operands → 0.
  - Both: out_valid the cycle after accept.
- Divide by zero:
  - divu 123 / 0 → 0xFFFF_FFFF_FFFF_FFFF.
  - remu 5 / 0 → 5.
  - remw src1 = 0x1_8000_0005, src2 = 0 → 0xFFFF_FFFF_8000_0005.
- W variants:
  - divw src1 = 0x0000_0001_8000_0000, src2 = -1 → 0xFFFF_FFFF_8000_0000 (fast path).
  - remw -7 / 2 → 0xFFFF_FFFF_FFFF_FFFF, latency 34.
  - mulw 0x1_0000_0002 × 3 → 6.
- Handshake and flush:
  - Hold out_ready = 0 for 10 cycles in DONE: result stays stable and in_ready stays 0.
  - Assert flush mid-CALC: IDLE next edge, in_ready = 1, no out_valid pulse.
  - Assert flush together with in_valid: the op is not accepted.
- Async reset mid-CALC: out_valid = 0 and in_ready = 1 immediately. A new mul 2 × 3 then returns 6.
